// File: rtl/toggle_arbiter_pkg.sv
// Shared definitions for the toggle arbiter: FSM encoding, default sizing, counter width.
// Optional toggle counter is enabled by defining TOGGLE_ARB_CNT_EN.
package toggle_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    HOLD  = 2'b10
  } arb_state_t;

  localparam int N_REQ_DEF       = 4;
  localparam int HOLD_CYCLES_DEF = 1;
  localparam int CNT_W           = 8;

endpackage

// File: rtl/toggle_arbiter_tflipflop.sv
// Shared toggle flip-flop: q inverts on every rising edge where t is high.
module tflipflop (
  input  logic t,
  input  logic ck,
  output logic q
);

  always_ff @(posedge ck) q <= q ^ t;

endmodule

// File: rtl/toggle_arbiter.sv
// Round-robin arbiter that grants one requester at a time the right to toggle a shared flip-flop.
// Define TOGGLE_ARB_CNT_EN to add the tog_cnt completed-toggle counter output.
module toggle_arbiter
  import toggle_arb_pkg::*;
#(
  parameter int N_REQ       = N_REQ_DEF,
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
  input  logic             ck,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic             t,
  output logic             q,
  output logic             busy
`ifdef TOGGLE_ARB_CNT_EN
  ,
  output logic [CNT_W-1:0] tog_cnt
`endif
);

  localparam int LW = $clog2(N_REQ);
  localparam int HW = 4;

  arb_state_t        state, state_n;
  logic [LW-1:0]     last, win, idx;
  logic [HW-1:0]     hold_cnt;
  logic              found;
  logic              ff_t;

  // Round-robin search starting just above the previous winner.
  always_comb begin
    win   = last;
    idx   = '0;
    found = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = LW'((int'(last) + i) % N_REQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_n = state;
    gnt     = '0;
    t       = 1'b0;
    busy    = 1'b0;
    case (state)
      IDLE:    if (|req) state_n = GRANT;
      GRANT: begin
        state_n   = HOLD;
        gnt[last] = 1'b1;
        t         = 1'b1;
        busy      = 1'b1;
      end
      HOLD: begin
        busy = 1'b1;
        if (hold_cnt == '0) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      state    <= IDLE;
      last     <= LW'(N_REQ - 1);
      hold_cnt <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && |req) last <= win;
      if (state == GRANT)
        hold_cnt <= HW'(HOLD_CYCLES - 1);
      else if (state == HOLD && hold_cnt != '0)
        hold_cnt <= hold_cnt - 1'b1;
    end
  end

  // The flop has no reset pin: during reset feed back q so it lands on 0 and the grant toggle is dropped.
  assign ff_t = rst ? q : t;

  tflipflop u_tff (
    .t  (ff_t),
    .ck (ck),
    .q  (q)
  );

`ifdef TOGGLE_ARB_CNT_EN
  always_ff @(posedge ck) begin
    if (rst)                 tog_cnt <= '0;
    else if (state == GRANT) tog_cnt <= tog_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_toggle_arbiter.sv
// Directed plus randomized check of toggle_arbiter against a cycle-count reference model.
module tb_toggle_arbiter;

  localparam int N = 4;
  localparam int H = 1;

  logic         ck = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req = '0;
  logic [N-1:0] gnt;
  logic         t, q, busy;
`ifdef TOGGLE_ARB_CNT_EN
  logic [7:0]   tog_cnt;
`endif

  always #5 ck = ~ck;

  toggle_arbiter #(.N_REQ(N), .HOLD_CYCLES(H)) dut (
    .ck   (ck),
    .rst  (rst),
    .req  (req),
    .gnt  (gnt),
    .t    (t),
    .q    (q),
    .busy (busy)
`ifdef TOGGLE_ARB_CNT_EN
    ,
    .tog_cnt (tog_cnt)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: a pending winner (-1 none), a cooldown count of idle-gap cycles, last winner, q, count.
  int  m_last = N - 1;
  int  m_win  = -1;
  int  m_cool = 0;
  bit  m_q    = 1'b0;
  int  m_cnt  = 0;
  logic [N-1:0] cur_req = '0;
  bit  auto_clr = 1'b1;

  function automatic void model_edge(bit r, logic [N-1:0] rq);
    if (r) begin
      m_q = 1'b0; m_last = N - 1; m_win = -1; m_cool = 0; m_cnt = 0;
    end else if (m_win >= 0) begin
      m_q = !m_q; m_cnt = (m_cnt + 1) % 256; m_last = m_win; m_win = -1; m_cool = H;
    end else if (m_cool > 0) begin
      m_cool--;
    end else if (rq != '0) begin
      for (int k = 1; k <= N; k++) begin
        int j;
        j = (m_last + k) % N;
        if (rq[j]) begin
          m_win = j;
          break;
        end
      end
    end
  endfunction

  function automatic logic [N-1:0] exp_gnt();
    logic [N-1:0] g;
    g = '0;
    if (m_win >= 0) g[m_win] = 1'b1;
    return g;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input bit r);
    logic [N-1:0] eg;
    rst = r;
    req = cur_req;
    @(posedge ck);
    model_edge(r, cur_req);
    @(negedge ck);
    eg = exp_gnt();
    chk("gnt",  32'(gnt),  32'(eg));
    chk("t",    32'(t),    32'(m_win >= 0));
    chk("busy", 32'(busy), 32'(m_win >= 0 || m_cool > 0));
    chk("q",    32'(q),    32'(m_q));
    chk("onehot", 32'($countones(gnt) <= 1), 32'(1));
`ifdef TOGGLE_ARB_CNT_EN
    chk("tog_cnt", 32'(tog_cnt), 32'(m_cnt));
`endif
    if (auto_clr) cur_req = cur_req & ~eg;
  endtask

  initial begin
    // reset for two cycles, then a single held request
    cur_req = '0;
    cyc(1'b1); cyc(1'b1);
    chk("reset_q", 32'(q), 32'(0));
    cur_req = 4'b0001;
    for (int i = 0; i < 5; i++) cyc(1'b0);

    // all requesters held continuously: round-robin rotation
    auto_clr = 1'b0;
    cur_req = 4'b1111;
    for (int i = 0; i < 16; i++) cyc(1'b0);
    auto_clr = 1'b1;
    cur_req = '0;
    for (int i = 0; i < 3; i++) cyc(1'b0);

    // simultaneous rise of two requests
    cur_req = 4'b0101;
    for (int i = 0; i < 8; i++) cyc(1'b0);

    // short pulse on req[2] while holding is ignored and dropped
    cur_req = 4'b0001;
    cyc(1'b0);
    cyc(1'b0);
    cur_req = 4'b0100;
    cyc(1'b0);
    cur_req = '0;
    for (int i = 0; i < 3; i++) cyc(1'b0);

    // reset during GRANT aborts the toggle; requester 0 has priority afterwards
    cur_req = 4'b0010;
    cyc(1'b0);
    cur_req = '0;
    cyc(1'b1);
    chk("abort_q", 32'(q), 32'(0));
    cur_req = 4'b1111;
    cyc(1'b0);
    chk("first_after_rst", 32'(gnt), 32'(4'b0001));
    for (int i = 0; i < 12; i++) cyc(1'b0);

    // randomized requests, drops and occasional resets
    cur_req = '0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) cur_req = cur_req | N'($urandom_range(0, (1 << N) - 1));
      if ($urandom_range(0, 15) == 0) cur_req[$urandom_range(0, N - 1)] = 1'b0;
      cyc($urandom_range(0, 49) == 0);
    end

`ifdef TOGGLE_ARB_CNT_EN
    // 256 grants wrap the counter and leave q back at 0
    cur_req = '0;
    cyc(1'b1);
    auto_clr = 1'b0;
    cur_req = 4'b0001;
    for (int i = 0; i < 256 * (H + 2); i++) cyc(1'b0);
    chk("cnt_wrap", 32'(tog_cnt), 32'(0));
    chk("cnt_wrap_q", 32'(q), 32'(0));
    auto_clr = 1'b1;
    cur_req = '0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/toggle_arbiter.md
TOGGLE_ARBITER -- requirements
Module: toggle_arbiter

Interface
REQ-001 The block SHALL have a parameter N_REQ, default 4, giving the number of requesters (2..8).
REQ-002 The block SHALL have a parameter HOLD_CYCLES, default 1, giving the idle gap after each grant (1..15).
REQ-003 The block SHALL have port ck  input  1  rising-edge clock; the block has one clock.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port req  input  N_REQ  per-requester toggle request, level, held until granted.
REQ-006 The block SHALL have port gnt  output  N_REQ  one-hot grant, one-cycle pulse.
REQ-007 The block SHALL have port t  output  1  toggle enable driven to the shared flip-flop.
REQ-008 The block SHALL have port q  output  1  state of the shared toggle flip-flop.
REQ-009 The block SHALL have port busy  output  1  high in GRANT and HOLD.

Function
REQ-010 The FSM SHALL have states IDLE, GRANT and HOLD.
REQ-011 In IDLE with req nonzero at a rising edge, the FSM SHALL enter GRANT on that edge, selecting one winner.
REQ-012 In IDLE with req zero, the FSM SHALL stay in IDLE.
REQ-013 In GRANT, for exactly one cycle, the block SHALL drive gnt[winner]=1 and t=1.
REQ-014 On the edge leaving GRANT, q SHALL invert, and the FSM SHALL enter HOLD.
REQ-015 In HOLD, the block SHALL drive gnt=0 and t=0 for HOLD_CYCLES cycles, then return to IDLE.
REQ-016 Request-to-grant latency SHALL be 1 cycle from IDLE.
REQ-017 The minimum spacing between successive grants SHALL be HOLD_CYCLES+2 cycles.
REQ-018 Round-robin: the winner SHALL be the first asserted req index searching upward from last+1 modulo N_REQ, where last is the previous winner.
REQ-019 When several req bits rise in the same cycle, exactly one gnt SHALL assert; the others wait.
REQ-020 A req bit deasserted before its grant SHALL be dropped with no grant and no toggle.
REQ-021 req changes during GRANT or HOLD SHALL be ignored until IDLE.
REQ-022 gnt SHALL never have more than one bit set.
REQ-023 t SHALL be high only in GRANT.

Reset
REQ-024 On rst=1 at a rising edge, the block SHALL force state=IDLE, gnt=0, t=0, q=0, busy=0 and last=N_REQ-1, so requester 0 has first priority.
REQ-025 rst asserted during GRANT or HOLD SHALL abort the operation; no toggle SHALL occur on the reset edge.
REQ-026 rst SHALL take priority over all other inputs.

Configuration
REQ-027 With TOGGLE_ARB_CNT_EN defined, the block SHALL add output port tog_cnt (8 bits), holding the count of completed toggles; it resets to 0, increments on each GRANT exit and wraps 255->0.
REQ-028 Without TOGGLE_ARB_CNT_EN, port tog_cnt and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-029 A shared package toggle_arb_pkg SHALL hold the FSM state encoding (IDLE=2'b00, GRANT=2'b01, HOLD=2'b10), the default N_REQ and HOLD_CYCLES values, and the counter width constant (8).
REQ-030 The shared flip-flop SHALL be the existing tflipflop sub-module (ports t, ck, q), instantiated once and driven by t; the reset of q is applied through that instance.
REQ-031 The round-robin search SHALL be combinational; the FSM, last pointer and hold counter SHALL be registered.

Verification
REQ-032 Scenario: rst for 2 cycles, then req=4'b0001 held -> gnt=0001 with t=1 one cycle later; q goes 0->1; busy is high for 2 cycles (HOLD_CYCLES=1).
REQ-033 Scenario: req=4'b1111 held continuously -> grants occur in order 0001, 0010, 0100, 1000, 0001, spaced 3 cycles apart; q toggles on each grant.
REQ-034 Scenario: req=4'b0101 rises in one cycle -> gnt=0001 first, then gnt=0100; gnt is never multi-hot.
REQ-035 Scenario: req[2] pulses for one cycle during HOLD, then drops -> no grant to requester 2 and q is unchanged.
REQ-036 Scenario: rst asserted during GRANT -> q=0, gnt=0 and state IDLE on the next cycle; the next req=0001 is granted first.
REQ-037 Scenario with TOGGLE_ARB_CNT_EN: 256 consecutive grants -> tog_cnt wraps to 0 and q ends at 0.
